// File: rtl/layer_mac_scheduler_if.sv
// layer_mac_scheduler_if: activation/weight/bias/result signal bundle for the MAC scheduler
// slave  (scheduler side): takes in_valid/in_vec, w_data, b_data, out_ready; drives in_ready, w_addr, b_addr, out_valid/idx/data, busy
// master (environment side): the mirror image
interface layer_mac_scheduler_if #(parameter int NUM_IN = 10, parameter int AW = 7);
  logic                  in_valid;
  logic                  in_ready;
  logic [8*NUM_IN-1:0]   in_vec;
  logic [AW-1:0]         w_addr;
  logic [7:0]            w_data;
  logic [2:0]            b_addr;
  logic [15:0]           b_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [2:0]            out_idx;
  logic [7:0]            out_data;
  logic                  busy;
  modport slave (input in_valid, in_vec, w_data, b_data, out_ready,
                 output in_ready, w_addr, b_addr, out_valid, out_idx, out_data, busy);
  modport master (output in_valid, in_vec, w_data, b_data, out_ready,
                  input in_ready, w_addr, b_addr, out_valid, out_idx, out_data, busy);
endinterface

// File: rtl/layer_mac_scheduler.sv
// layer_mac_scheduler: sequences NUM_IN-long signed MACs for NUM_OUT neurons and quantizes each to 0..127
// clk/reset: clock and synchronous active-high reset
// bus (slave): vector intake (in_valid/in_ready/in_vec), weight ROM (w_addr -> w_data next cycle),
//              bias ROM (b_addr -> b_data), result stream (out_valid/out_ready/out_idx/out_data), busy
module layer_mac_scheduler #(
  parameter int NUM_IN  = 10,
  parameter int NUM_OUT = 8,
  parameter int AW      = 7
) (
  input logic clk,
  input logic reset,
  layer_mac_scheduler_if.slave bus
);
  localparam int IW = $clog2(NUM_IN + 1);
  typedef enum logic [2:0] {IDLE, FETCH, DRAIN, QUANT, OUT} state_t;
  state_t state_q, state_d;
  logic [8*NUM_IN-1:0] vec_q, vec_d;
  logic [IW-1:0] i_q, i_d, p;
  logic [2:0] n_q, n_d, oi_q, oi_d;
  logic [AW-1:0] addr_q, addr_d;
  logic signed [22:0] acc_q, acc_d, prod_ext, bias_ext;
  logic [7:0] od_q, od_d, rnd, q;
  logic signed [7:0] a;
  logic signed [15:0] prod;
  always_comb begin
    // product for the address issued last cycle, whose weight is on w_data now
    p = i_q - IW'(1);
    a = 8'(vec_q >> {p, 3'b000});
    prod = a * $signed(bus.w_data);
    prod_ext = {{7{prod[15]}}, prod};
    bias_ext = {{7{bus.b_data[15]}}, bus.b_data};
    rnd = {1'b0, acc_q[12:6]} + {7'b0, acc_q[5]};
    q = acc_q[22] ? 8'd0 : |acc_q[21:13] ? 8'd127 : rnd[7] ? 8'd127 : rnd;
    state_d = state_q;
    vec_d = vec_q;
    i_d = i_q;
    n_d = n_q;
    addr_d = addr_q;
    acc_d = acc_q;
    od_d = od_q;
    oi_d = oi_q;
    case (state_q)
      IDLE: if (bus.in_valid) begin
        vec_d = bus.in_vec;
        n_d = 3'd0;
        i_d = '0;
        addr_d = '0;
        acc_d = '0;
        state_d = FETCH;
      end
      FETCH: begin
        // bias is loaded on the first fetch cycle, when b_addr already shows the new neuron
        acc_d = (i_q == '0) ? bias_ext : acc_q + prod_ext;
        // w_addr runs continuously, so it already points at the next neuron's first weight
        addr_d = addr_q + AW'(1);
        i_d = i_q + IW'(1);
        state_d = (i_q == IW'(NUM_IN - 1)) ? DRAIN : FETCH;
      end
      DRAIN: begin
        acc_d = acc_q + prod_ext;
        state_d = QUANT;
      end
      QUANT: begin
        od_d = q;
        oi_d = n_q;
        state_d = OUT;
      end
      OUT: if (bus.out_ready) begin
        if (n_q == 3'(NUM_OUT - 1)) state_d = IDLE;
        else begin
          n_d = n_q + 3'd1;
          i_d = '0;
          state_d = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      vec_q <= '0;
      i_q <= '0;
      n_q <= '0;
      addr_q <= '0;
      acc_q <= '0;
      od_q <= '0;
      oi_q <= '0;
    end else begin
      state_q <= state_d;
      vec_q <= vec_d;
      i_q <= i_d;
      n_q <= n_d;
      addr_q <= addr_d;
      acc_q <= acc_d;
      od_q <= od_d;
      oi_q <= oi_d;
    end
  end
  assign bus.in_ready = state_q == IDLE;
  assign bus.busy = state_q != IDLE;
  assign bus.out_valid = state_q == OUT;
  assign bus.w_addr = addr_q;
  assign bus.b_addr = n_q;
  assign bus.out_idx = oi_q;
  assign bus.out_data = od_q;
endmodule

// File: tb/tb_layer_mac_scheduler.sv
// tb_layer_mac_scheduler: table-driven, corner-case and randomized checks of layer_mac_scheduler
module tb_layer_mac_scheduler;
  localparam int NI = 10, NO = 8, AW = 7;
  logic clk = 0, reset = 1;
  always #5 clk = ~clk;
  layer_mac_scheduler_if #(.NUM_IN(NI), .AW(AW)) ifc ();
  layer_mac_scheduler #(.NUM_IN(NI), .NUM_OUT(NO), .AW(AW)) dut (.clk(clk), .reset(reset), .bus(ifc));
  int act [NI];
  int wrom [1 << AW];
  int brom [NO];
  int exp_d [NO];
  int cyc = 0, t_acc = 0, t_hs = 0, n_cmp = 0, n_bad = 0;
  typedef struct {int a0; int ar; int w0; int wr; int b; int e;} vec_t;
  vec_t tbl [5];
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) ifc.w_data <= 8'(wrom[ifc.w_addr]);
  assign ifc.b_data = 16'(brom[ifc.b_addr]);
  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, $signed(got), $signed(want));
    end
  endtask
  function automatic logic [8*NI-1:0] pack_act();
    logic [8*NI-1:0] v;
    for (int i = 0; i < NI; i++) v[8*i +: 8] = 8'(act[i]);
    return v;
  endfunction
  function automatic int model(input int n);
    int s;
    logic signed [22:0] acc;
    int r;
    s = brom[n];
    for (int i = 0; i < NI; i++) s += act[i] * wrom[n*NI + i];
    acc = s[22:0];
    if (acc < 0) return 0;
    if (acc >= 8192) return 127;
    r = (int'(acc) + 32) / 64;
    return r > 127 ? 127 : r;
  endfunction
  task automatic send(input logic [8*NI-1:0] v);
    int w = 0;
    while (!ifc.in_ready && w < 100) begin @(negedge clk); w++; end
    check("in_ready_before_send", ifc.in_ready, 1);
    ifc.in_valid = 1;
    ifc.in_vec = v;
    t_acc = cyc;
    @(negedge clk);
    ifc.in_vec = {$urandom, $urandom, $urandom};
    repeat (3) @(negedge clk);
    ifc.in_valid = 0;
  endtask
  task automatic recv(input int cnt, input int stall_n, input int stall_len, input bit rnd);
    for (int n = 0; n < cnt; n++) begin
      int w = 0;
      logic [AW-1:0] hold;
      ifc.out_ready = 1;
      while (!ifc.out_valid && w < 100) begin @(negedge clk); w++; end
      check("out_valid", ifc.out_valid, 1);
      check(n == 0 ? "latency_first" : "latency_next", cyc - (n == 0 ? t_acc : t_hs), NI + 3);
      check("out_idx", ifc.out_idx, n);
      check("out_data", ifc.out_data, exp_d[n]);
      if (n == stall_n) begin
        ifc.out_ready = 0;
        hold = ifc.w_addr;
        repeat (stall_len) begin
          @(negedge clk);
          check("stall_valid", ifc.out_valid, 1);
          check("stall_idx", ifc.out_idx, n);
          check("stall_data", ifc.out_data, exp_d[n]);
          check("stall_w_addr", ifc.w_addr, hold);
        end
        ifc.out_ready = 1;
      end else if (rnd && $urandom_range(0, 2) == 0) begin
        ifc.out_ready = 0;
        repeat ($urandom_range(1, 4)) @(negedge clk);
        ifc.out_ready = 1;
      end
      t_hs = cyc;
      @(negedge clk);
    end
    if (cnt == NO) check("in_ready_after_last", ifc.in_ready, 1);
  endtask
  task automatic randomize_data();
    int k;
    for (int i = 0; i < NI; i++) act[i] = int'($urandom_range(0, 255)) - 128;
    for (int j = 0; j < NI*NO; j++) begin
      k = $urandom_range(0, 5);
      wrom[j] = (int'($urandom_range(0, 255)) - 128) / (1 << k);
    end
    for (int n = 0; n < NO; n++) brom[n] = int'($urandom_range(0, 8191)) - 4096;
    for (int n = 0; n < NO; n++) exp_d[n] = model(n);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    int seen;
    tbl[0] = '{64, 64, 1, 1, 0, 10};
    tbl[1] = '{64, 64, -1, -1, 0, 0};
    tbl[2] = '{127, 127, 127, 127, 0, 127};
    tbl[3] = '{127, 0, 64, 0, 32, 127};
    tbl[4] = '{96, 0, 1, 0, 0, 2};
    ifc.in_valid = 0;
    ifc.in_vec = '0;
    ifc.out_ready = 1;
    repeat (3) @(negedge clk);
    check("rst_in_ready", ifc.in_ready, 1);
    check("rst_busy", ifc.busy, 0);
    check("rst_out_valid", ifc.out_valid, 0);
    check("rst_w_addr", ifc.w_addr, 0);
    check("rst_b_addr", ifc.b_addr, 0);
    check("rst_out_data", ifc.out_data, 0);
    check("rst_out_idx", ifc.out_idx, 0);
    reset = 0;
    @(negedge clk);
    for (int t = 0; t < 5; t++) begin
      for (int i = 0; i < NI; i++) act[i] = i == 0 ? tbl[t].a0 : tbl[t].ar;
      for (int j = 0; j < NI*NO; j++) wrom[j] = (j % NI) == 0 ? tbl[t].w0 : tbl[t].wr;
      for (int n = 0; n < NO; n++) begin brom[n] = tbl[t].b; exp_d[n] = tbl[t].e; end
      send(pack_act());
      recv(NO, -1, 0, 0);
    end
    randomize_data();
    send(pack_act());
    recv(NO, 3, 5, 0);
    for (int r = 0; r < 4; r++) begin
      randomize_data();
      send(pack_act());
      recv(NO, -1, 0, 1);
    end
    randomize_data();
    send(pack_act());
    recv(2, -1, 0, 0);
    repeat (2) @(negedge clk);
    check("abort_in_fetch_n2_busy", ifc.busy, 1);
    check("abort_in_fetch_n2_b_addr", ifc.b_addr, 2);
    reset = 1;
    @(negedge clk);
    reset = 0;
    check("abort_in_ready", ifc.in_ready, 1);
    check("abort_busy", ifc.busy, 0);
    check("abort_w_addr", ifc.w_addr, 0);
    check("abort_b_addr", ifc.b_addr, 0);
    seen = 0;
    repeat (30) begin @(negedge clk); if (ifc.out_valid) seen++; end
    check("abort_no_out_valid", seen, 0);
    randomize_data();
    send(pack_act());
    recv(NO, -1, 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
